// File: rtl/mac_feeder_pkg.sv
// Shared feeder types: scalar MAC operand, float word macro and FSM state enum.
// MM-array control reuses feeder_state_e and the default length from here.
`ifndef SINGLE
`define SINGLE logic [31:0]
`endif

package mac_feeder_pkg;

    localparam int MAC_FEEDER_MAX_LEN = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } feeder_state_e;

    typedef struct packed {
        logic   valid;
        `SINGLE value;
    } Scalar;

    function automatic int sat_len(input int n, input int lim);
        return (n > lim) ? lim : n;
    endfunction

endpackage

// File: rtl/mac_feeder_if.sv
// Bundle between the feeder, operand buffer, MAC lane and result consumer.
// The stall input exists only when MAC_FEEDER_STALL_EN is defined.
interface mac_feeder_if
    import mac_feeder_pkg::*;
#(
    parameter int MAX_LEN = MAC_FEEDER_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int ADDR_W  = $clog2(MAX_LEN)
) ();
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data_x;
    logic [31:0]       rd_data_w;
    logic              mac_clear;
    Scalar             mac_data;
    Scalar             mac_weight;
    `SINGLE            mac_out;
    logic              res_valid;
    logic              res_ready;
    `SINGLE            res_data;
`ifdef MAC_FEEDER_STALL_EN
    logic              stall;
`endif

    modport master (
        input  start, len, rd_data_x, rd_data_w, mac_out, res_ready,
`ifdef MAC_FEEDER_STALL_EN
        input  stall,
`endif
        output busy, rd_en, rd_addr, mac_clear, mac_data, mac_weight,
        output res_valid, res_data
    );

    modport slave (
        output start, len, rd_data_x, rd_data_w, mac_out, res_ready,
`ifdef MAC_FEEDER_STALL_EN
        output stall,
`endif
        input  busy, rd_en, rd_addr, mac_clear, mac_data, mac_weight,
        input  res_valid, res_data
    );

endinterface

// File: rtl/mac_feeder.sv
// Sequencer feeding one MAC lane from a 1-cycle-latency operand buffer.
// MAC_FEEDER_STALL_EN adds a stall input that re-reads the current element.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for start; len sampled and saturated here
//   ST_CLEAR | clear MAC, prefetch element 0 when len > 0
//   ST_FEED  | present element i, prefetch i+1 (or re-read i on stall)
//   ST_DRAIN | MAC output complete, capture it into res_data
//   ST_DONE  | offer result until res_ready
module mac_feeder
    import mac_feeder_pkg::*;
#(
    parameter int MAX_LEN = MAC_FEEDER_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int ADDR_W  = $clog2(MAX_LEN)
) (
    input logic          clk,
    input logic          rst,
    mac_feeder_if.master bus
);

    feeder_state_e    state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    `SINGLE           res_q, res_d;
    `SINGLE           x_hold_q, x_hold_d;
    `SINGLE           w_hold_q, w_hold_d;
    logic             feed_valid;
    logic             stall_now;

`ifdef MAC_FEEDER_STALL_EN
    assign stall_now = bus.stall;
`else
    assign stall_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            x_hold_q <= '0;
            w_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            x_hold_q <= x_hold_d;
            w_hold_q <= w_hold_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        res_d         = res_q;
        feed_valid    = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        bus.mac_clear = 1'b0;
        bus.res_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    len_d   = LEN_W'(sat_len(int'(bus.len), MAX_LEN));
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                bus.mac_clear = 1'b1;
                cnt_d         = '0;
                if (len_q != '0) begin
                    bus.rd_en = 1'b1;
                    state_d   = ST_FEED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FEED: begin
                if (stall_now) begin
                    bus.rd_en   = 1'b1;
                    bus.rd_addr = ADDR_W'(cnt_q);
                end else begin
                    feed_valid = 1'b1;
                    cnt_d      = cnt_q + LEN_W'(1);
                    if ((cnt_q + LEN_W'(1)) < len_q) begin
                        bus.rd_en   = 1'b1;
                        bus.rd_addr = ADDR_W'(cnt_q + LEN_W'(1));
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                res_d   = bus.mac_out;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // operand values track the buffer while valid and hold otherwise
        x_hold_d       = feed_valid ? bus.rd_data_x : x_hold_q;
        w_hold_d       = feed_valid ? bus.rd_data_w : w_hold_q;
        bus.mac_data   = '{valid: feed_valid, value: x_hold_d};
        bus.mac_weight = '{valid: feed_valid, value: w_hold_d};
        bus.busy       = (state_q != ST_IDLE);
        bus.res_data   = res_q;
    end

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder with a behavioural operand buffer and float MAC lane.
module tb_mac_feeder;
    import mac_feeder_pkg::*;

    localparam int MAX_LEN = MAC_FEEDER_MAX_LEN;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_feeder_if #(.MAX_LEN(MAX_LEN)) bus ();
    mac_feeder #(.MAX_LEN(MAX_LEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic real sp2real(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'h0) return 0.0;
        d = {b[31], 11'({3'b000, b[30:23]} + 11'd896), b[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    logic [31:0] mem_x [MAX_LEN];
    logic [31:0] mem_w [MAX_LEN];
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data_x <= mem_x[bus.rd_addr];
            bus.rd_data_w <= mem_w[bus.rd_addr];
        end
    end

    logic [31:0] acc = 32'h0;
    always @(posedge clk) begin
        if (bus.mac_clear)
            acc <= 32'h0;
        else if (bus.mac_data.valid && bus.mac_weight.valid)
            acc <= real2sp(sp2real(acc) +
                           sp2real(bus.mac_data.value) * sp2real(bus.mac_weight.value));
    end
    assign bus.mac_out = acc;

    int unsigned cyc = 0, n_rd = 0, n_clr = 0, n_acc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (bus.rd_en) n_rd <= n_rd + 1;
            if (bus.mac_clear) n_clr <= n_clr + 1;
            if (bus.mac_data.valid) n_acc <= n_acc + 1;
        end
    end

    int n_checks = 0, n_pass = 0;
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, " ctrl"}, {bus.busy, bus.rd_en, bus.mac_clear, bus.mac_data.valid,
                                  bus.mac_weight.valid, bus.res_valid}, 6'b0);
        check_eq({tag, " rd_addr"}, bus.rd_addr, 0);
        check_eq({tag, " values"}, {bus.mac_data.value, bus.mac_weight.value}, 0);
        check_eq({tag, " res_data"}, bus.res_data, 0);
    endtask

    int          stall_mode = 0;
    logic [31:0] stall_mask = 32'h0;
    int unsigned job_stamp  = 0;

    function automatic logic pick_stall(input int c);
        if (stall_mode == 1) return (c < 32) ? stall_mask[c] : 1'b0;
        if (stall_mode == 2) return $urandom_range(1) == 1;
        return 1'b0;
    endfunction

    // Expected timing: CLEAR in cycle 1, FEED for len+stalls cycles, DRAIN, then DONE.
    task automatic run_job(input int n, input logic [31:0] exp_res, input int ready_delay,
                           input string tag);
        int          eff, lat, stalls, consumed;
        int unsigned rd0, clr0, acc0;
        logic        s;
        logic [31:0] held;
        eff      = (n > MAX_LEN) ? MAX_LEN : n;
        lat      = 0;
        stalls   = 0;
        consumed = 0;
        bus.res_ready = (ready_delay == 0);
        bus.len       = LEN_W'(n);
        bus.start     = 1'b1;
        rd0  = n_rd;
        clr0 = n_clr;
        acc0 = n_acc;
        @(posedge clk);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start = 1'b0;
                job_stamp = cyc;
            end
            if (bus.res_valid) begin
                lat = c;
                break;
            end
            s = pick_stall(c);
`ifdef MAC_FEEDER_STALL_EN
            bus.stall = s;
`endif
            if (c >= 2 && consumed < eff) begin
                if (s) stalls++;
                else consumed++;
            end
        end
`ifdef MAC_FEEDER_STALL_EN
        bus.stall = 1'b0;
`endif
        if (lat == 0) begin
            check_eq({tag, " timeout"}, 0, 1);
            return;
        end
        check_eq({tag, " latency"}, lat, eff + stalls + 3);
        check_eq({tag, " result"}, bus.res_data, exp_res);
        check_eq({tag, " reads"}, n_rd - rd0, (eff == 0) ? 0 : eff + stalls);
        check_eq({tag, " clears"}, n_clr - clr0, 1);
        check_eq({tag, " accepted"}, n_acc - acc0, eff);
        held = bus.res_data;
        for (int d = 0; d < ready_delay; d++) begin
            bus.start = 1'b1;
            bus.len   = LEN_W'(1);
            @(negedge clk);
            check_eq({tag, " hold data"}, bus.res_data, held);
            check_eq({tag, " hold valid/busy"}, {bus.res_valid, bus.busy}, 2'b11);
        end
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, " release"}, {bus.res_valid, bus.busy}, 2'b00);
        if (ready_delay > 0) begin
            @(negedge clk);
            check_eq({tag, " start not queued"}, bus.busy, 1'b0);
        end
    endtask

    task automatic fill_const(input int n, input logic [31:0] x, input logic [31:0] w);
        for (int k = 0; k < n; k++) begin
            mem_x[k] = x;
            mem_w[k] = w;
        end
    endtask

    initial begin
        int unsigned sa;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.res_ready = 1'b0;
`ifdef MAC_FEEDER_STALL_EN
        bus.stall     = 1'b0;
`endif
        fill_const(MAX_LEN, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            mem_x[k] = real2sp(real'(k + 1));
            mem_w[k] = 32'h3F80_0000;
        end
        run_job(4, 32'h4120_0000, 0, "len4");
        run_job(0, 32'h0000_0000, 0, "len0");

        fill_const(2, 32'h4000_0000, 32'h4040_0000);
        run_job(2, 32'h4140_0000, 0, "b2b_a");
        sa = job_stamp;
        mem_x[0] = 32'h3F80_0000;
        mem_w[0] = 32'hBF80_0000;
        run_job(1, 32'hBF80_0000, 0, "b2b_b");
        check_eq("b2b period", job_stamp - sa, 6);

        fill_const(8, 32'h3F80_0000, 32'h3F80_0000);
        run_job(3, 32'h4040_0000, 5, "hold");

        bus.len   = LEN_W'(8);
        bus.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check_eq("mid feed valid", bus.mac_data.valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid rst");
        rst = 1'b0;
        run_job(3, 32'h4040_0000, 0, "after rst");

`ifdef MAC_FEEDER_STALL_EN
        stall_mode = 1;
        stall_mask = 32'h0000_000C;
        run_job(4, 32'h4080_0000, 0, "stall");
        stall_mode = 0;
`endif

        for (int j = 0; j < 10; j++) begin
            int n, eff, sum, vx, vw;
            n   = (j == 3) ? MAX_LEN + 3 : int'($urandom_range(12));
            eff = (n > MAX_LEN) ? MAX_LEN : n;
            sum = 0;
            for (int k = 0; k < MAX_LEN; k++) begin
                vx = int'($urandom_range(16)) - 8;
                vw = int'($urandom_range(16)) - 8;
                mem_x[k] = real2sp(real'(vx));
                mem_w[k] = real2sp(real'(vw));
                if (k < eff) sum += vx * vw;
            end
`ifdef MAC_FEEDER_STALL_EN
            stall_mode = (j % 2 == 1) ? 2 : 0;
`endif
            run_job(n, real2sp(real'(sum)), int'($urandom_range(2)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
